sensor_debouncer: RTL and testbench



---
 rtl/irrigation_pkg.sv | 15 +
 rtl/debounce_ch.sv | 133 +++++++++++++
 rtl/sensor_debouncer.sv | 70 +++++++
 tb/tb_sensor_debouncer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared constants for the irrigation controller sensor front end.
// Channel index constants name the bit positions of the sensor bus; the
// defaults are the parameter values used when a block is instantiated bare.
package irrigation_pkg;

    localparam int unsigned CH_US   = 0;  // soil humidity
    localparam int unsigned CH_BS   = 1;  // level
    localparam int unsigned CH_VS   = 2;  // valve / flow
    localparam int unsigned CH_ADUB = 3;  // fertiliser request

    localparam int unsigned NCH_DEFAULT         = 4;
    localparam int unsigned DEB_COUNT_DEFAULT   = 8;
    localparam int unsigned FAULT_LIMIT_DEFAULT = 15;

endpackage

// File: rtl/debounce_ch.sv
// Single-channel sensor conditioner: 2-flop synchronizer, tick-gated debounce
// counter, debounced level and one-cycle rise/fall pulses.
// Optional chatter detection is compiled in with the DEB_FAULT_EN macro.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous, active-high reset
//   tick     - sample enable for the debounce counter
//   raw      - asynchronous raw sensor level
//   stable   - debounced level
//   rise     - one-clk pulse when stable goes 0->1
//   fall     - one-clk pulse when stable goes 1->0
//   clrFault - clears fault and abort counter (DEB_FAULT_EN only)
//   fault    - sticky chatter flag (DEB_FAULT_EN only)
module debounce_ch
    import irrigation_pkg::*;
#(
    parameter int unsigned DEB_COUNT   = DEB_COUNT_DEFAULT,
    parameter int unsigned CW          = $clog2(DEB_COUNT)
`ifdef DEB_FAULT_EN
    ,
    parameter int unsigned FAULT_LIMIT = FAULT_LIMIT_DEFAULT
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
`ifdef DEB_FAULT_EN
    ,
    input  logic clrFault,
    output logic fault
`endif
);

    localparam logic [CW-1:0] CntMax = CW'(DEB_COUNT - 1);

    logic          s1Q, s2Q;
    logic          stableQ, stableD;
    logic [CW-1:0] cntQ, cntD;
    logic          riseQ, riseD;
    logic          fallQ, fallD;

    always_comb begin
        cntD    = cntQ;
        stableD = stableQ;
        riseD   = 1'b0;
        fallD   = 1'b0;
        if (tick) begin
            if (s2Q == stableQ) begin
                cntD = '0;
            end else if (cntQ == CntMax) begin
                stableD = s2Q;
                cntD    = '0;
                riseD   = s2Q;
                fallD   = ~s2Q;
            end else begin
                cntD = cntQ + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Q     <= 1'b0;
            s2Q     <= 1'b0;
            stableQ <= 1'b0;
            cntQ    <= '0;
            riseQ   <= 1'b0;
            fallQ   <= 1'b0;
        end else begin
            // Synchronizer runs every clock, independent of tick.
            s1Q     <= raw;
            s2Q     <= s1Q;
            stableQ <= stableD;
            cntQ    <= cntD;
            riseQ   <= riseD;
            fallQ   <= fallD;
        end
    end

    assign stable = stableQ;
    assign rise   = riseQ;
    assign fall   = fallQ;

`ifdef DEB_FAULT_EN
    localparam int unsigned   AW       = $clog2(FAULT_LIMIT + 1);
    localparam logic [AW-1:0] AbortMax = AW'(FAULT_LIMIT);
    localparam logic [AW-1:0] AbortHit = AW'(FAULT_LIMIT - 1);

    logic          abortEv, acceptEv, hit;
    logic [AW-1:0] abortQ, abortD;
    logic          faultQ, faultD;

    // A bounce abort is a pending count thrown away because the input fell back.
    assign abortEv  = tick && (s2Q == stableQ) && (cntQ != '0);
    assign acceptEv = tick && (s2Q != stableQ) && (cntQ == CntMax);
    assign hit      = abortEv && (abortQ == AbortHit);

    always_comb begin
        abortD = abortQ;
        faultD = faultQ | hit;
        if (acceptEv) begin
            abortD = '0;
        end else if (abortEv && (abortQ != AbortMax)) begin
            abortD = abortQ + 1'b1;
        end
        // A limit hit on the same edge as a clear keeps the flag set.
        if (clrFault) begin
            faultD = hit;
            if (!hit) begin
                abortD = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abortQ <= '0;
            faultQ <= 1'b0;
        end else begin
            abortQ <= abortD;
            faultQ <= faultD;
        end
    end

    assign fault = faultQ;
`endif

endmodule

// File: rtl/sensor_debouncer.sv
// Conditions the raw field-sensor inputs (Us, Bs, Vs, Adub) for the irrigation
// control top: one debounce_ch per channel plus a combined change strobe.
// Optional per-channel chatter fault flags are compiled in with DEB_FAULT_EN.
//
// Ports:
//   Clk       - system clock
//   Rst       - synchronous, active-high reset
//   Tick      - sample enable from the clock divider (tie to 1 for every Clk)
//   Raw       - asynchronous raw sensor levels, bit order CH_US..CH_ADUB
//   Stable    - debounced levels
//   Rise      - one-Clk pulse per channel on a 0->1 acceptance
//   Fall      - one-Clk pulse per channel on a 1->0 acceptance
//   Changed   - OR of all Rise and Fall bits, same cycle
//   Clr_Fault - clears all Fault bits (DEB_FAULT_EN only)
//   Fault     - sticky chatter flag per channel (DEB_FAULT_EN only)
module sensor_debouncer
    import irrigation_pkg::*;
#(
    parameter int unsigned NCH         = NCH_DEFAULT,
    parameter int unsigned DEB_COUNT   = DEB_COUNT_DEFAULT,
    parameter int unsigned CW          = $clog2(DEB_COUNT)
`ifdef DEB_FAULT_EN
    ,
    parameter int unsigned FAULT_LIMIT = FAULT_LIMIT_DEFAULT
`endif
) (
    input  logic           Clk,
    input  logic           Rst,
    input  logic           Tick,
    input  logic [NCH-1:0] Raw,
    output logic [NCH-1:0] Stable,
    output logic [NCH-1:0] Rise,
    output logic [NCH-1:0] Fall,
    output logic           Changed
`ifdef DEB_FAULT_EN
    ,
    input  logic           Clr_Fault,
    output logic [NCH-1:0] Fault
`endif
);

    for (genvar i = 0; i < NCH; i++) begin : gCh
        debounce_ch #(
            .DEB_COUNT   (DEB_COUNT),
            .CW          (CW)
`ifdef DEB_FAULT_EN
            ,
            .FAULT_LIMIT (FAULT_LIMIT)
`endif
        ) uCh (
            .clk      (Clk),
            .rst      (Rst),
            .tick     (Tick),
            .raw      (Raw[i]),
            .stable   (Stable[i]),
            .rise     (Rise[i]),
            .fall     (Fall[i])
`ifdef DEB_FAULT_EN
            ,
            .clrFault (Clr_Fault),
            .fault    (Fault[i])
`endif
        );
    end

    // Built from the registered pulses, so it is aligned with them and free of
    // any extra combinational depth from the debounce logic.
    assign Changed = |{Rise, Fall};

endmodule

// File: tb/tb_sensor_debouncer.sv
module tb_sensor_debouncer;

    localparam int NCH = 4;
    localparam int DEB = 8;
    localparam int FLIM = 15;

    logic           Clk = 1'b0;
    logic           Rst;
    logic           Tick;
    logic [NCH-1:0] Raw;
    logic [NCH-1:0] Stable, Rise, Fall;
    logic           Changed;
`ifdef DEB_FAULT_EN
    logic           clrFault;
    logic [NCH-1:0] fault;
`endif

    always #5 Clk = ~Clk;

    sensor_debouncer dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Tick      (Tick),
        .Raw       (Raw),
        .Stable    (Stable),
        .Rise      (Rise),
        .Fall      (Fall),
`ifdef DEB_FAULT_EN
        .Clr_Fault (clrFault),
        .Fault     (fault),
`endif
        .Changed   (Changed)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw is seen through a two-clock delay line; a level is
    // accepted after DEB consecutive tick samples differ from the stable level.
    logic [NCH-1:0] mD1, mD2, mStable, mRise, mFall;
    int             mRun [NCH];
`ifdef DEB_FAULT_EN
    logic [NCH-1:0] mFault;
    int             mAbort [NCH];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelEdge();
        logic [NCH-1:0] sample;
        logic [NCH-1:0] hit;
        hit = '0;
        if (Rst) begin
            mD1 = '0; mD2 = '0; mStable = '0; mRise = '0; mFall = '0;
            for (int c = 0; c < NCH; c++) mRun[c] = 0;
`ifdef DEB_FAULT_EN
            mFault = '0;
            for (int c = 0; c < NCH; c++) mAbort[c] = 0;
`endif
        end else begin
            sample = mD2;
            mD2 = mD1;
            mD1 = Raw;
            mRise = '0;
            mFall = '0;
            if (Tick) begin
                for (int c = 0; c < NCH; c++) begin
                    if (sample[c] == mStable[c]) begin
`ifdef DEB_FAULT_EN
                        if (mRun[c] > 0 && mAbort[c] < FLIM) begin
                            mAbort[c]++;
                            if (mAbort[c] == FLIM) begin
                                mFault[c] = 1'b1;
                                hit[c] = 1'b1;
                            end
                        end
`endif
                        mRun[c] = 0;
                    end else begin
                        mRun[c]++;
                        if (mRun[c] == DEB) begin
                            mStable[c] = sample[c];
                            mRise[c] = sample[c];
                            mFall[c] = ~sample[c];
                            mRun[c] = 0;
`ifdef DEB_FAULT_EN
                            mAbort[c] = 0;
`endif
                        end
                    end
                end
            end
`ifdef DEB_FAULT_EN
            if (clrFault) begin
                for (int c = 0; c < NCH; c++) begin
                    if (!hit[c]) begin
                        mFault[c] = 1'b0;
                        mAbort[c] = 0;
                    end
                end
            end
`endif
        end
    endtask

    // Drive at negedge, let one posedge happen, then compare 1 time unit later.
    task automatic step(input logic rst, input logic tick, input logic [NCH-1:0] raw);
        Rst = rst;
        Tick = tick;
        Raw = raw;
        @(posedge Clk);
        modelEdge();
        #1;
        check("stable", Stable, mStable);
        check("rise", Rise, mRise);
        check("fall", Fall, mFall);
        check("changed", Changed, |{mRise, mFall});
`ifdef DEB_FAULT_EN
        check("fault", fault, mFault);
`endif
        @(negedge Clk);
    endtask

    initial begin
        int pulses;
        logic [NCH-1:0] r;
        Rst = 1'b1;
        Tick = 1'b1;
        Raw = '0;
`ifdef DEB_FAULT_EN
        clrFault = 1'b0;
`endif
        @(negedge Clk);

        // Reset with all inputs high, then release.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 4'hF);
        check("rst_stable", Stable, 4'h0);
        check("rst_changed", Changed, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 4'hF);
            if (k == 8) check("rel_before", Stable, 4'h0);
            if (k == 9) begin
                check("rel_stable", Stable, 4'hF);
                check("rel_rise", Rise, 4'hF);
                check("rel_changed", Changed, 1'b1);
            end
            if (k == 10) check("rel_pulse_end", Rise, 4'h0);
        end

        // All low, then a clean rise and fall on channel 0.
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 4'h0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 4'h1);
            if (k == 8) check("clean_early", Stable[0], 1'b0);
            if (k == 9) check("clean_rise", Rise, 4'h1);
        end
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 4'h0);
            if (k == 9) check("clean_fall", Fall, 4'h1);
        end

        // Bounce on channel 1: 5 high, 2 low, then steady high.
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 4'h2);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 4'h0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 4'h2);
            if (Rise[1]) pulses++;
            if (k == 8) check("bounce_early", Stable[1], 1'b0);
            if (k == 9) check("bounce_rise", Rise[1], 1'b1);
        end
        check("bounce_pulses", pulses, 1);

        // Tick every 4th clock, channel 2 rises.
        pulses = 0;
        for (int n = 0; n < 48; n++) begin
            step(1'b0, (n % 4) == 3, 4'h6);
            if (Rise[2]) pulses++;
        end
        check("gate_pulses", pulses, 1);
        check("gate_stable", Stable, 4'h6);

        // Reset in the middle of a channel 3 count.
        for (int k = 0; k < 17; k++) begin
            step(k == 5, 1'b1, 4'hE);
            if (k == 14) check("midrst_early", Stable[3], 1'b0);
            if (k == 15) check("midrst_stable", Stable[3], 1'b1);
        end

`ifdef DEB_FAULT_EN
        // Chatter on channel 0: toggle every 3 clocks with Tick held high.
        r = 4'hE;
        for (int k = 0; k < 150; k++) begin
            if (k % 3 == 0) r[0] = ~r[0];
            step(1'b0, 1'b1, r);
        end
        check("chatter_fault", fault[0], 1'b1);
        clrFault = 1'b1;
        step(1'b0, 1'b1, 4'hE);
        clrFault = 1'b0;
        check("chatter_clr", fault[0], 1'b0);
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 4'hF);
        check("clean_after_clr", fault[0], 1'b0);
`endif

        // Random phase: alternate choppy and calm blocks, random tick and rare resets.
        r = Raw;
        for (int n = 0; n < 3000; n++) begin
            int den;
            den = ((n / 200) % 2 == 0) ? 4 : 40;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(den - 1) == 0) r[c] = ~r[c];
`ifdef DEB_FAULT_EN
            clrFault = ($urandom_range(49) == 0);
`endif
            step($urandom_range(499) == 0, $urandom_range(3) != 0, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
